// File: rtl/uart_tx_engine.sv
// uart_tx_engine: TX byte FIFO feeding an 8-bit frame serializer.
// Frame format and bit period are latched per byte at pop time.
module uart_tx_engine #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [15:0]      baud_div,
  input  logic             par_en,
  input  logic             stop2,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop, full, empty;

  state_t      state, state_n;
  logic [15:0] timer, timer_n;
  logic [15:0] div_q, div_n;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  shifter, shift_n;
  logic        par_q, par_n;
  logic        stop2_q, stop2_n;
  logic        tx_q, tx_n;
  logic        bit_end, load;

  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign push       = wr_valid && !full;
  assign wr_ready   = !full;
  assign fifo_count = count;
  assign tx         = tx_q;
  assign busy       = (state != IDLE) || !empty;
  assign bit_end    = (timer == div_q);

  // FIFO storage; contents are don't-care until the pointers say otherwise
  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers and occupancy; pointers wrap at the power-of-two depth
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Serializer state, bit timer, latched frame config and registered line
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shifter <= '0;
      div_q   <= '0;
      par_q   <= 1'b0;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      bit_idx <= bit_n;
      shifter <= shift_n;
      div_q   <= div_n;
      par_q   <= par_n;
      stop2_q <= stop2_n;
      tx_q    <= tx_n;
    end
  end

  // Next-state logic; tx_n is the line level for the cycle after the edge
  always_comb begin
    state_n = state;
    timer_n = timer + 16'd1;
    bit_n   = bit_idx;
    shift_n = shifter;
    div_n   = div_q;
    par_n   = par_q;
    stop2_n = stop2_q;
    tx_n    = tx_q;
    load    = 1'b0;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        timer_n = '0;
        tx_n    = 1'b1;
        if (!empty) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          timer_n = '0;
          bit_n   = '0;
          tx_n    = shifter[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_n = '0;
          if (bit_idx == 3'd7) begin
            bit_n = '0;
            if (par_q) begin
              state_n = PARITY;
              tx_n    = ^shifter;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_n = bit_idx + 3'd1;
            tx_n  = shifter[bit_n];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          timer_n = '0;
          bit_n   = '0;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          timer_n = '0;
          tx_n    = 1'b1;
          if (stop2_q && bit_idx == 3'd0) begin
            bit_n = 3'd1;
          end else if (!empty) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
    if (load) begin
      pop     = 1'b1;
      shift_n = mem[rd_ptr];
      div_n   = baud_div;
      par_n   = par_en;
      stop2_n = stop2;
      state_n = START;
      timer_n = '0;
      bit_n   = '0;
      tx_n    = 1'b0;
    end
  end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Transmit half of the UART IP. Sits directly downstream of the AXI4-Lite slave register block: bytes written to the TX data register are handed to this block over a valid/ready handshake, buffered in a small FIFO and serialized onto the `tx` pin. Frame format and baud divisor come from the control registers of the slave block.

## Interface
Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; power of two, minimum 2
- CNT_W, 5, width of `fifo_count`; equals log2(FIFO_DEPTH)+1

Ports:
- ACLK  in  1  sole clock; all logic on rising edge
- ARESET  in  1  reset, asynchronous assert, active-high; one clock and asynchronous active-high reset (ACLK/ARESET), fixed
- baud_div  in  16  bit period minus one, in ACLK cycles
- par_en  in  1  1 = append even parity bit
- stop2  in  1  1 = two stop bits, 0 = one
- wr_data  in  8  byte to transmit
- wr_valid  in  1  wr_data valid
- wr_ready  out  1  FIFO can accept; equals !full
- tx  out  1  serial line, idle high, registered
- busy  out  1  frame in progress or FIFO non-empty
- fifo_count  out  CNT_W  bytes currently in FIFO (excludes byte in shifter)

## Operation
- Push when wr_valid && wr_ready at a rising edge. wr_ready depends only on full, not on a same-cycle pop.
- FIFO: circular buffer, read/write pointers wrap at FIFO_DEPTH, count tracks occupancy. Simultaneous push and pop leave count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If FIFO non-empty: pop into 8-bit shifter, latch baud_div/par_en/stop2 for the frame, go to START.
  - START: tx=0 for one bit period, then DATA.
  - DATA: 8 bits, LSB first, one bit period each; bit index counter 0..7. After bit 7: PARITY if par_en latched, else STOP.
  - PARITY: tx = XOR of the 8 data bits (even parity), one bit period, then STOP.
  - STOP: tx=1 for 1 or 2 bit periods. At the end: if FIFO non-empty, pop and go directly to START in the same edge (no idle gap); else go to IDLE.
- Bit timer: counts 0..baud_div_latched, bit period = baud_div+1 cycles; baud_div=0 gives 1 cycle/bit. Timer reloads to 0 on every state/bit transition.
- Config changes mid-frame take effect at the next frame only.
- busy = (state != IDLE) || (count != 0).

## Timing
- Reset values: tx=1, wr_ready=1, busy=0, fifo_count=0, state IDLE, pointers 0, shifter 0.
- ARESET mid-frame: tx returns to 1 asynchronously; FIFO contents discarded; no partial frame resumes after release.
- Latency: byte accepted at edge N into empty FIFO with FSM in IDLE -> popped at edge N+1, tx falls at edge N+1 (one cycle after accept).
- Frame length in cycles: (baud_div+1) × (10 + par_en + stop2).
- Back-to-back: next start bit begins on the cycle after the last stop-bit cycle.
- Full: with a continuous writer and a long bit period, 1 + FIFO_DEPTH bytes are accepted (one into the shifter), then wr_ready=0 until the next pop. Pop at edge M -> wr_ready=1 after edge M.
- Empty: FSM stays in IDLE and tx=1. No underflow possible.

## Test plan
- Reset, baud_div=3, par_en=0, stop2=0, write 0x55 -> tx=0 one cycle after accept; tx bits 0,1,0,1,0,1,0,1,0,1 each 4 cycles (40 cycles total); busy low on the cycle after the stop bit ends; tx stays 1.
- baud_div=0, par_en=1, stop2=1, write 0x07 -> 12-cycle frame: start 0, data 1,1,1,0,0,0,0,0, parity 1, stop 1,1.
- baud_div=1, write 0xA3 then 0x3C in consecutive cycles -> two 20-cycle frames with zero idle cycles between them; decoded bytes are 0xA3 then 0x3C.
- baud_div=100, hold wr_valid=1 with incrementing data 0x00.. -> exactly 17 bytes accepted, wr_ready=0, fifo_count=16; after the first frame completes, one more byte is accepted; all bytes are decoded in order with none lost.
- Change baud_div from 3 to 7 in the middle of a frame -> current frame keeps 4 cycles/bit; the next frame uses 8 cycles/bit.
- Assert ARESET during DATA with 5 bytes queued -> tx=1 immediately, fifo_count=0, busy=0; after release tx stays 1 with no further frames.
